// File: rtl/mem_responder.sv
// mem_responder: main-memory model answering cache fills and single-word writes.
// One request is in flight at a time. After a fixed latency a read returns
// an aligned block one word per cycle, and a write returns a one-cycle ack.
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int BURST   = 8,
  parameter int AW      = 16,
  parameter int DEPTH_W = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   req_wdata,
  output logic          rsp_valid,
  output logic [15:0]   rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_last,
  output logic          wr_ack,
  output logic          busy
);

  localparam int BW = $clog2(BURST);
  localparam logic [DEPTH_W-1:0] BLK_MASK = DEPTH_W'(BURST - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST,
    ST_WACK
  } state_t;

  state_t              state_q;
  logic [3:0]          lat_q;
  logic [BW-1:0]       beat_q;
  logic [DEPTH_W-1:0]  word_q;
  logic                we_q;
  logic [15:0]         wdata_q;
  logic                rsp_valid_q;
  logic                rsp_last_q;
  logic [15:0]         rsp_data_q;
  logic [AW-1:0]       rsp_addr_q;
  logic                wr_ack_q;

  logic [15:0]         mem [0:(1<<DEPTH_W)-1];

  logic [DEPTH_W-1:0]  req_word;
  logic [DEPTH_W-1:0]  beat_base_d;
  logic [BW-1:0]       beat_idx_d;
  logic [DEPTH_W-1:0]  beat_word_d;
  logic [15:0]         rd_data_d;
  logic                unusedAddrBits;

  // Bit 0 and any bits above the array depth never select storage; the
  // space aliases with wrap-around at 2^DEPTH_W words.
  assign req_word       = req_addr[DEPTH_W:1];
  assign unusedAddrBits = ^req_addr;

  // Address and array data of the beat that the next rising edge will emit.
  always_comb begin
    beat_base_d = word_q & ~BLK_MASK;
    beat_idx_d  = beat_q;
    if (state_q == ST_IDLE) begin
      beat_base_d = req_word & ~BLK_MASK;
      beat_idx_d  = '0;
    end else if (state_q == ST_WAIT) begin
      beat_idx_d  = '0;
    end
    beat_word_d = beat_base_d | DEPTH_W'(beat_idx_d);
    rd_data_d   = mem[beat_word_d];
  end

  // Control FSM with registered response outputs. lat_q counts down through
  // WAIT so that the first beat or ack lands in cycle LATENCY after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      word_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      wr_ack_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            word_q  <= req_word;
            wdata_q <= req_wdata;
            if (LATENCY == 1) begin
              lat_q <= '0;
              if (req_we) begin
                state_q  <= ST_WACK;
                wr_ack_q <= 1'b1;
              end else begin
                state_q     <= ST_BURST;
                rsp_valid_q <= 1'b1;
                rsp_addr_q  <= AW'({beat_word_d, 1'b0});
                rsp_data_q  <= rd_data_d;
                rsp_last_q  <= (beat_idx_d == LAST_BEAT);
                beat_q      <= beat_idx_d + 1'b1;
              end
            end else begin
              state_q <= ST_WAIT;
              lat_q   <= 4'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          lat_q <= lat_q - 1'b1;
          if (lat_q == 4'd1) begin
            if (we_q) begin
              state_q  <= ST_WACK;
              wr_ack_q <= 1'b1;
            end else begin
              state_q     <= ST_BURST;
              rsp_valid_q <= 1'b1;
              rsp_addr_q  <= AW'({beat_word_d, 1'b0});
              rsp_data_q  <= rd_data_d;
              rsp_last_q  <= (beat_idx_d == LAST_BEAT);
              beat_q      <= beat_idx_d + 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (rsp_last_q) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            beat_q      <= '0;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_addr_q  <= AW'({beat_word_d, 1'b0});
            rsp_data_q  <= rd_data_d;
            rsp_last_q  <= (beat_idx_d == LAST_BEAT);
            beat_q      <= beat_idx_d + 1'b1;
          end
        end
        ST_WACK: begin
          state_q  <= ST_IDLE;
          wr_ack_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage array has no reset; a write commits on the edge ending the ack
  // cycle, so a reset during WAIT leaves the location untouched.
  always_ff @(posedge clk) begin
    if (state_q == ST_WACK) begin
      mem[word_q] <= wdata_q;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_last  = rsp_last_q;
  assign wr_ack    = wr_ack_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder timing, data and reset
// behaviour, plus a second instance with a short latency/burst and a
// reduced array depth that exercises address aliasing.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_last, wr_ack, busy;
  logic [15:0] rsp_data, rsp_addr;

  logic        sReqValid, sReqReady, sReqWe;
  logic [15:0] sReqAddr, sReqWdata;
  logic        sRspValid, sRspLast, sWrAck, sBusy;
  logic [15:0] sRspData, sRspAddr;

  int          checks = 0;
  int          failures = 0;

  logic [15:0] beatData [0:7];
  int          beatCount;

  mem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_last  (rsp_last),
    .wr_ack    (wr_ack),
    .busy      (busy)
  );

  mem_responder #(.LATENCY(1), .BURST(2), .AW(16), .DEPTH_W(14)) dutSweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (sReqValid),
    .req_ready (sReqReady),
    .req_we    (sReqWe),
    .req_addr  (sReqAddr),
    .req_wdata (sReqWdata),
    .rsp_valid (sRspValid),
    .rsp_data  (sRspData),
    .rsp_addr  (sRspAddr),
    .rsp_last  (sRspLast),
    .wr_ack    (sWrAck),
    .busy      (sBusy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Present one request at a negedge; it is accepted on the following posedge
  // (end of cycle 0). Returns #1 into cycle 1 with req_valid dropped.
  task automatic issueReq(input logic we, input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL issue_ready got=%b exp=1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Issue a write and return the cycle in which wr_ack appeared (-1 if never).
  task automatic doWrite(input logic [15:0] addr, input logic [15:0] data, output int ackCycle);
    issueReq(1'b1, addr, data);
    ackCycle = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) begin
        ackCycle = cyc;
        break;
      end
    end
    checks++;
    if (ackCycle < 0) begin
      failures++;
      $display("[TB] FAIL write_ack_timeout addr=%h got=none exp=ack", addr);
    end
  endtask

  // Issue a read and record every beat into beatData/beatCount.
  task automatic captureBurst(input logic [15:0] addr);
    issueReq(1'b0, addr, 16'h0000);
    beatCount = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (beatCount < 8) beatData[beatCount] = rsp_data;
        beatCount++;
      end
      if (rsp_last === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_last got=%b exp=0", rsp_last); end
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack got=%b exp=0", wr_ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0000", rsp_data); end
    checks++; if (rsp_addr !== 16'h0000) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0000", rsp_addr); end
    checks++; if (sReqReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_sweep_ready got=%b exp=1", sReqReady); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle got=ready%b/busy%b exp=ready1/busy0", req_ready, busy); end
  endtask

  task automatic test_read_burst();
    logic expValid;
    issueReq(1'b0, 16'h0024, 16'h0000);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      expValid = (cyc >= 4 && cyc <= 11);
      checks++;
      if (rsp_valid !== expValid) begin failures++; $display("[TB] FAIL read_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, expValid); end
      if (expValid) begin
        checks++;
        if (rsp_addr !== 16'(16'h0020 + 2 * (cyc - 4))) begin
          failures++; $display("[TB] FAIL read_addr cyc=%0d got=%h exp=%h", cyc, rsp_addr, 16'(16'h0020 + 2 * (cyc - 4)));
        end
      end
      checks++;
      if (rsp_last !== (cyc == 11)) begin failures++; $display("[TB] FAIL read_last cyc=%0d got=%b exp=%b", cyc, rsp_last, (cyc == 11)); end
      checks++;
      if (req_ready !== (cyc == 12)) begin failures++; $display("[TB] FAIL read_ready cyc=%0d got=%b exp=%b", cyc, req_ready, (cyc == 12)); end
    end
  endtask

  task automatic test_write_read();
    int ackCyc;
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      doWrite(16'(16'h0100 + 2 * i), 16'(16'hA000 + i), ackCyc);
    end
    doWrite(16'h0102, 16'hBEEF, ackCyc);
    checks++;
    if (ackCyc != 4) begin failures++; $display("[TB] FAIL write_ack_cycle got=%0d exp=4", ackCyc); end
    captureBurst(16'h0100);
    checks++;
    if (beatCount != 8) begin failures++; $display("[TB] FAIL write_read_beats got=%0d exp=8", beatCount); end
    for (int k = 0; k < 8; k++) begin
      exp = (k == 1) ? 16'hBEEF : 16'(16'hA000 + k);
      checks++;
      if (beatData[k] !== exp) begin failures++; $display("[TB] FAIL write_read_data beat=%0d got=%h exp=%h", k, beatData[k], exp); end
    end
  endtask

  task automatic test_back_to_back();
    int acceptCyc, ackCyc, ackCount, earlyAck;
    logic lastSeen;
    issueReq(1'b0, 16'h0100, 16'h0000);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0104;
    req_wdata = 16'h1234;
    acceptCyc = -1; ackCyc = -1; ackCount = 0; earlyAck = 0; lastSeen = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) begin
        ackCount++;
        if (!lastSeen) earlyAck++;
        if (ackCyc < 0) ackCyc = cyc;
      end
      if (rsp_last === 1'b1) lastSeen = 1'b1;
      if (acceptCyc < 0 && req_ready === 1'b1 && req_valid) acceptCyc = cyc;
      else if (acceptCyc >= 0 && cyc == acceptCyc + 1) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++; if (earlyAck != 0) begin failures++; $display("[TB] FAIL busy_early_ack got=%0d exp=0", earlyAck); end
    checks++; if (acceptCyc != 12) begin failures++; $display("[TB] FAIL busy_accept_cycle got=%0d exp=12", acceptCyc); end
    checks++; if (ackCyc != 16) begin failures++; $display("[TB] FAIL busy_ack_cycle got=%0d exp=16", ackCyc); end
    checks++; if (ackCount != 1) begin failures++; $display("[TB] FAIL busy_ack_count got=%0d exp=1", ackCount); end
    captureBurst(16'h0100);
    checks++; if (beatData[2] !== 16'h1234) begin failures++; $display("[TB] FAIL busy_write_data got=%h exp=1234", beatData[2]); end
  endtask

  task automatic test_reset_mid();
    int beats, acks;
    issueReq(1'b0, 16'h0100, 16'h0000);
    for (int cyc = 1; cyc <= 7; cyc++) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_addr !== 16'h0106) begin failures++; $display("[TB] FAIL mid_beat3 got=v%b/%h exp=v1/0106", rsp_valid, rsp_addr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_addr !== 16'h0000 || rsp_data !== 16'h0000) begin failures++; $display("[TB] FAIL mid_rst_addrdata got=%h/%h exp=0000/0000", rsp_addr, rsp_data); end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_state got=ready%b/busy%b exp=ready1/busy0", req_ready, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    beats = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) beats++;
    end
    checks++; if (beats != 0) begin failures++; $display("[TB] FAIL mid_rst_beats got=%0d exp=0", beats); end

    issueReq(1'b1, 16'h0108, 16'h5555);
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL wr_wait_busy got=%b exp=1", busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wr_ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL wr_rst_state got=ack%b/busy%b exp=ack0/busy0", wr_ack, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("[TB] FAIL wr_rst_acks got=%0d exp=0", acks); end
    captureBurst(16'h0100);
    checks++; if (beatCount != 8) begin failures++; $display("[TB] FAIL wr_rst_beats got=%0d exp=8", beatCount); end
    checks++; if (beatData[4] !== 16'hA008 - 16'h0004) begin failures++; $display("[TB] FAIL wr_rst_keep got=%h exp=%h", beatData[4], 16'hA004); end
  endtask

  task automatic test_sweep();
    logic [15:0] wAddr [0:1];
    logic [15:0] wData [0:1];
    wAddr[0] = 16'h7FFC; wData[0] = 16'h1111;
    wAddr[1] = 16'hFFFE; wData[1] = 16'hCAFE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sReqValid = 1'b1; sReqWe = 1'b1; sReqAddr = wAddr[i]; sReqWdata = wData[i];
      @(posedge clk);
      #1 sReqValid = 1'b0;
      @(negedge clk);
      checks++; if (sWrAck !== 1'b1) begin failures++; $display("[TB] FAIL sweep_ack_c1 idx=%0d got=%b exp=1", i, sWrAck); end
      @(negedge clk);
      checks++; if (sWrAck !== 1'b0 || sReqReady !== 1'b1) begin failures++; $display("[TB] FAIL sweep_ack_c2 idx=%0d got=ack%b/ready%b exp=ack0/ready1", i, sWrAck, sReqReady); end
    end
    @(negedge clk);
    sReqValid = 1'b1; sReqWe = 1'b0; sReqAddr = 16'hFFFE;
    @(posedge clk);
    #1 sReqValid = 1'b0;
    @(negedge clk);
    checks++; if (sRspValid !== 1'b1 || sRspLast !== 1'b0) begin failures++; $display("[TB] FAIL sweep_c1_flags got=v%b/l%b exp=v1/l0", sRspValid, sRspLast); end
    checks++; if (sRspAddr !== 16'h7FFC || sRspData !== 16'h1111) begin failures++; $display("[TB] FAIL sweep_c1_beat got=%h/%h exp=7FFC/1111", sRspAddr, sRspData); end
    @(negedge clk);
    checks++; if (sRspValid !== 1'b1 || sRspLast !== 1'b1) begin failures++; $display("[TB] FAIL sweep_c2_flags got=v%b/l%b exp=v1/l1", sRspValid, sRspLast); end
    checks++; if (sRspAddr !== 16'h7FFE || sRspData !== 16'hCAFE) begin failures++; $display("[TB] FAIL sweep_c2_beat got=%h/%h exp=7FFE/CAFE", sRspAddr, sRspData); end
    @(negedge clk);
    checks++; if (sRspValid !== 1'b0 || sReqReady !== 1'b1) begin failures++; $display("[TB] FAIL sweep_c3 got=v%b/ready%b exp=v0/ready1", sRspValid, sReqReady); end
  endtask

  // Hard time limit so the bench always ends even if the design hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    sReqValid = 1'b0; sReqWe = 1'b0; sReqAddr = '0; sReqWdata = '0;
    rst_n = 1'b0;
    test_reset();
    test_read_burst();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
